// File: rtl/alu_share_arb_if.sv
// Request/response bundle for the shared signed adder: two requester ports
// plus one response port and the completed-operation counter.
interface alu_share_arb_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_of;
  logic             rsp_cf;
  logic             rsp_zf;
  logic             rsp_nf;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_of, rsp_cf, rsp_zf, rsp_nf, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_of, rsp_cf, rsp_zf, rsp_nf, ops_done
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one signed add/subtract unit between two
// requesters; one operation in flight, registered result and flags.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic             r_sub;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_of;
  logic             r_rsp_cf;
  logic             r_rsp_zf;
  logic             r_rsp_nf;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_of;

  // Contention goes to whoever did not win last time.
  always_comb begin
    // NOTE: default assignment first so every path drives w_grant (no latch).
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) w_grant = ~r_last_grant;
    else if (bus.req1_valid)              w_grant = 1'b1;
  end

  assign bus.req0_ready = (r_state == S_IDLE) && bus.req0_valid && !w_grant;
  assign bus.req1_ready = (r_state == S_IDLE) && bus.req1_valid &&  w_grant;
  assign w_accept       = bus.req0_ready || bus.req1_ready;

  // Subtract is a + ~b + 1; the carry-out doubles as the "no borrow" flag.
  assign w_b_eff = r_sub ? ~r_b : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_sub};
  assign w_of    = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sub        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_out    <= '0;
      r_rsp_of     <= 1'b0;
      r_rsp_cf     <= 1'b0;
      r_rsp_zf     <= 1'b0;
      r_rsp_nf     <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant ? bus.req1_a   : bus.req0_a;
            r_b          <= w_grant ? bus.req1_b   : bus.req0_b;
            r_sub        <= w_grant ? bus.req1_sub : bus.req0_sub;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_out   <= w_sum[WIDTH-1:0];
          r_rsp_cf    <= w_sum[WIDTH];
          r_rsp_of    <= w_of;
          r_rsp_zf    <= (w_sum[WIDTH-1:0] == '0);
          r_rsp_nf    <= w_sum[WIDTH-1];
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_of    = r_rsp_of;
  assign bus.rsp_cf    = r_rsp_cf;
  assign bus.rsp_zf    = r_rsp_zf;
  assign bus.rsp_nf    = r_rsp_nf;
  assign bus.ops_done  = r_ops_done;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer around one shared 32-bit signed add/subtract unit with flags. Each requester presents operands and an opcode through a valid/ready handshake. The block grants requesters round-robin, runs one operation at a time through the internal adder, and returns a registered result with overflow, carry, zero and negative flags through a valid/ready response port. It sits between the instruction/control logic and the signed adder datapath, so several masters can share a single adder.

## Interface
- WIDTH, 32, operand/result width in bits (signed two's complement)
- CNT_W, 16, width of the completed-operation counter

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 signed operands
- req0_sub  in  1  requester 0 opcode: 0 = a+b, 1 = a-b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  1  index of the requester that owns the result
- rsp_out  out  WIDTH  signed result
- rsp_of, rsp_cf, rsp_zf, rsp_nf  out  1 each  overflow, carry, zero and negative flags
- ops_done  out  CNT_W  count of responses consumed; wraps to 0

## Operation
- FSM states:
  - IDLE: may accept a request.
  - EXEC: latched operands pass through the adder; the result and flags are registered.
  - RESP: holds the response until it is consumed.
- Transitions:
  - IDLE→EXEC on accept.
  - EXEC→RESP unconditionally.
  - RESP→IDLE when rsp_valid && rsp_ready.
- Grant rule, evaluated combinationally in IDLE only:
  - One valid requester: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins first.
- reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high per cycle. Both readys are 0 outside IDLE.
- Accept = reqN_valid && reqN_ready at a rising edge. On accept: latch a, b, sub and id; set last_grant = id.
- Requesters hold valid and operands stable until ready. A requester may not drop valid before it is accepted.
- Arithmetic, with cin = sub:
  - b' = sub ? ~b : b
  - {carry, out} = a + b' + cin, computed at WIDTH+1 bits
  - cf = carry; for subtract, cf = 1 means no borrow
  - of = (a[MSB]==b'[MSB]) && (out[MSB]!=a[MSB])
  - zf = (out==0)
  - nf = out[MSB]
- ops_done increments by 1 on each response handshake and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, last_grant = 1.
  - rsp_valid, rsp_id, rsp_out, all flags and ops_done = 0.
  - Any in-flight operation is discarded; no response is issued for it.
- Latency: accept at edge N → rsp_valid high after edge N+1 → response stable from then until its handshake edge.
- rsp_id, rsp_out and the flags are registered. They do not change while rsp_valid && !rsp_ready.
- Earliest next accept is the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- If a requester's valid rises while another op is in flight, it waits. Arbitration happens on the first IDLE cycle.
- A response handshake and a new accept never occur in the same cycle.
- Reset asserted during EXEC or RESP: outputs clear immediately. After release, arbitration restarts with requester 0 priority.

## Test plan
- Req0: a=2147483647, b=1, sub=0 → rsp_out=0x80000000 (-2147483648), of=1, cf=0, zf=0, nf=1, rsp_id=0, rsp_valid 2 cycles after accept edge.
- Req1: a=6754276, b=-6754276, sub=0 → out=0, zf=1, cf=1, of=0, nf=0, rsp_id=1. Req0: a=5, b=7, sub=1 → out=-2, cf=0, nf=1, of=0.
- Both valid continuously from reset with rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - Responses carry the matching ids and operands.
  - ops_done=4 after the 4th response.
- rsp_ready held low 5 cycles with req1 valid:
  - rsp_out and flags stay stable.
  - req1_ready stays 0.
  - req1 is accepted on the cycle after rsp_ready rises and the handshake completes.
- Assert rst in EXEC:
  - rsp_valid never rises for that op.
  - All outputs are 0 within the reset cycle.
  - After release, both valid → req0 is granted first.
- Preload ops_done=0xFFFF by running 65535 ops, then one more response → ops_done=0.
